// File: rtl/paddle_input_cond.sv
// Synchronises and debounces both DB9 joystick ports and the mode button,
// and owns the 2/4-player flag toggled by a long press of the mode button.
//
// state    | meaning
// ST_IDLE  | waiting for a debounced rising edge of the mode button
// ST_PRESS | button held, counting towards the toggle
// ST_WAIT  | toggle done, waiting for release
module paddle_input_cond #(
  parameter int DEB_CYCLES  = 4000,
  parameter int HOLD_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] i_joy1_raw,
  input  logic [7:0] i_joy2_raw,
  input  logic       i_mode_btn,
  output logic [7:0] o_joy1,
  output logic [7:0] o_joy2,
  output logic       o_four_players,
  output logic       o_mode_pulse
);

  localparam int NCH = 17;
  // joystick bits idle high (released), the button idles low
  localparam logic [NCH-1:0] RST_VAL   = 17'h0FFFF;
  localparam logic [11:0]    DEB_LAST  = 12'(DEB_CYCLES - 1);
  localparam logic [19:0]    HOLD_LAST = 20'(HOLD_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRESS = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [NCH-1:0] raw;
  logic [NCH-1:0] s1;
  logic [NCH-1:0] s2;
  logic [NCH-1:0] d;
  logic [11:0]    cnt [NCH];

  logic       b;
  logic       b_q;
  logic [1:0] state;
  logic [19:0] hcnt;

  assign raw = {i_mode_btn, i_joy2_raw, i_joy1_raw};
  assign b   = d[16];

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      d  <= RST_VAL;
      for (int i = 0; i < NCH; i++) cnt[i] <= 12'd0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < NCH; i++) begin
        if (s2[i] == d[i]) begin
          cnt[i] <= 12'd0;
        end else if (cnt[i] == DEB_LAST) begin
          d[i]   <= s2[i];
          cnt[i] <= 12'd0;
        end else begin
          cnt[i] <= cnt[i] + 12'd1;
        end
      end
    end
  end

  assign o_joy1 = d[7:0];
  assign o_joy2 = d[15:8];

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      hcnt           <= 20'd0;
      b_q            <= 1'b0;
      o_four_players <= 1'b0;
      o_mode_pulse   <= 1'b0;
    end else begin
      b_q          <= b;
      o_mode_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          hcnt <= 20'd0;
          if (b && !b_q) state <= ST_PRESS;
        end
        ST_PRESS: begin
          // release takes priority over a toggle due on the same edge
          if (!b) begin
            state <= ST_IDLE;
            hcnt  <= 20'd0;
          end else if (hcnt == HOLD_LAST) begin
            o_four_players <= ~o_four_players;
            o_mode_pulse   <= 1'b1;
            state          <= ST_WAIT;
            hcnt           <= 20'd0;
          end else begin
            hcnt <= hcnt + 20'd1;
          end
        end
        ST_WAIT: begin
          hcnt <= 20'd0;
          if (!b) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          hcnt  <= 20'd0;
        end
      endcase
    end
  end

endmodule
